wb_stage_pipe: RTL and testbench

//  Parametrised MEM/WB pipeline register plus writeback select for the MIPS core.
//  - Replaces the combinational MemToReg mux with a registered stage.
//  - Extracts and extends sub-word loads from the memory read word.
//  - Supports stall and flush.
//  - Drives the register-file write port one cycle after capture.

---
 rtl/wb_stage_pipe.sv | 123 ++++++++++++
 tb/tb_wb_stage_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// ============================================================================
// Module   : wb_stage_pipe
// Purpose  : Registered MEM/WB stage with big-endian sub-word load extraction
//            and register-file write port drive. Optional macro WB_LINK_EN
//            adds the jal/jalr link-address writeback source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFS_W      = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_unsigned,
    input  logic [OFS_W-1:0]      in_addr_ofs,
    input  logic [DATA_W-1:0]     in_read_data,
    input  logic [DATA_W-1:0]     in_alu_result,
`ifdef WB_LINK_EN
    input  logic                  in_link,
    input  logic [DATA_W-1:0]     in_pc_plus4,
`endif
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  wb_valid,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data
);

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    logic [OFS_W-1:0]      w_ofsSel;
    logic [DATA_W-1:0]     w_shifted;
    logic [7:0]            w_field8;
    logic [15:0]           w_field16;
    logic [31:0]           w_field32;
    logic [DATA_W-1:0]     w_loadData;
    logic [DATA_W-1:0]     w_selData;
    logic                  w_regWrite;

    logic                  r_wbValid;
    logic                  r_regWrite;
    logic [REG_ADDR_W-1:0] r_writeReg;
    logic [DATA_W-1:0]     r_writeData;

    // Misaligned offsets align down to the access size; full-width ignores it.
    always_comb begin
        w_ofsSel = '0;
        case (in_load_size)
            c_SIZE_BYTE: w_ofsSel = in_addr_ofs;
            c_SIZE_HALF: w_ofsSel = in_addr_ofs & ~OFS_W'(1);
            c_SIZE_WORD: w_ofsSel = in_addr_ofs & ~OFS_W'(3);
            default:     w_ofsSel = '0;
        endcase
    end

    // Big-endian: byte at offset a moves to the top of the word.
    assign w_shifted = in_read_data << {w_ofsSel, 3'b000};
    assign w_field8  = w_shifted[DATA_W-1 -: 8];
    assign w_field16 = w_shifted[DATA_W-1 -: 16];
    assign w_field32 = w_shifted[DATA_W-1 -: 32];

    always_comb begin
        w_loadData = in_read_data;
        case (in_load_size)
            c_SIZE_BYTE: w_loadData = in_load_unsigned ? DATA_W'(w_field8)
                                                       : DATA_W'($signed(w_field8));
            c_SIZE_HALF: w_loadData = in_load_unsigned ? DATA_W'(w_field16)
                                                       : DATA_W'($signed(w_field16));
            c_SIZE_WORD: w_loadData = in_load_unsigned ? DATA_W'(w_field32)
                                                       : DATA_W'($signed(w_field32));
            default:     w_loadData = in_read_data;
        endcase
    end

`ifdef WB_LINK_EN
    always_comb begin
        w_selData = in_mem_to_reg ? w_loadData : in_alu_result;
        if (in_link) begin
            w_selData = in_pc_plus4;
        end
    end
`else
    assign w_selData = in_mem_to_reg ? w_loadData : in_alu_result;
`endif

    assign w_regWrite = in_valid & in_reg_write & (in_write_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbValid   <= 1'b0;
            r_regWrite  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else if (flush) begin
            r_wbValid   <= 1'b0;
            r_regWrite  <= 1'b0;
        end else if (!stall) begin
            r_wbValid   <= in_valid;
            r_regWrite  <= w_regWrite;
            r_writeReg  <= in_write_reg;
            r_writeData <= w_selData;
        end
    end

    assign wb_valid   = r_wbValid;
    assign reg_write  = r_regWrite;
    assign write_reg  = r_writeReg;
    assign write_data = r_writeData;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
// ============================================================================
// Module   : tb_wb_stage_pipe
// Purpose  : Scoreboard bench for wb_stage_pipe with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        inValid, inRegWrite, inMemToReg, inLoadUnsigned;
    logic [1:0]  inLoadSize, inAddrOfs;
    logic [31:0] inReadData, inAluResult;
    logic [4:0]  inWriteReg;
    logic        inLink;
    logic [31:0] inPcPlus4;
    logic        wbValid, regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        chkData;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .OFS_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .in_valid        (inValid),
        .in_reg_write    (inRegWrite),
        .in_mem_to_reg   (inMemToReg),
        .in_load_size    (inLoadSize),
        .in_load_unsigned(inLoadUnsigned),
        .in_addr_ofs     (inAddrOfs),
        .in_read_data    (inReadData),
        .in_alu_result   (inAluResult),
`ifdef WB_LINK_EN
        .in_link         (inLink),
        .in_pc_plus4     (inPcPlus4),
`endif
        .in_write_reg    (inWriteReg),
        .wb_valid        (wbValid),
        .reg_write       (regWrite),
        .write_reg       (writeReg),
        .write_data      (writeData)
    );

    // Monitor: each edge with a pending expectation is checked 1 ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                vectors++;
                if (wbValid !== e.v || regWrite !== e.rw ||
                    (e.chkData && (writeReg !== e.wr || writeData !== e.wd))) begin
                    miscompares++;
                    $display("FAIL %s: got v=%b rw=%b wr=%0d wd=%h, expected v=%b rw=%b wr=%0d wd=%h%s",
                             e.name, wbValid, regWrite, writeReg, writeData,
                             e.v, e.rw, e.wr, e.wd, e.chkData ? "" : " (wr/wd unchecked)");
                end
            end
        end
    end

    task automatic apply(
        input logic        iRst, iStall, iFlush,
        input logic        iValid, iRw, iM2r,
        input logic [1:0]  iSize,
        input logic        iUns,
        input logic [1:0]  iOfs,
        input logic [31:0] iRd, iAlu,
        input logic [4:0]  iWr,
        input logic        iLink,
        input logic [31:0] iPc,
        input logic        eV, eRw,
        input logic [4:0]  eWr,
        input logic [31:0] eWd,
        input logic        eChk,
        input string       name);
        exp_t e;
        @(negedge clk);
        rst = iRst; stall = iStall; flush = iFlush;
        inValid = iValid; inRegWrite = iRw; inMemToReg = iM2r;
        inLoadSize = iSize; inLoadUnsigned = iUns; inAddrOfs = iOfs;
        inReadData = iRd; inAluResult = iAlu; inWriteReg = iWr;
        inLink = iLink; inPcPlus4 = iPc;
        e.v = eV; e.rw = eRw; e.wr = eWr; e.wd = eWd; e.chkData = eChk; e.name = name;
        expQ.push_back(e);
    endtask

    localparam logic [31:0] c_RD = 32'h80F17F01;

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            apply(1, $urandom_range(1), $urandom_range(1), 1, 1, $urandom_range(1),
                  2'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                  5'($urandom), 0, $urandom, 0, 0, 5'd0, 32'h0, 1, "reset");
        end
        //      rst st fl v rw m2r sz uns ofs rd    alu           wr  lk pc    eV eRw eWr  eWd            chk
        apply(0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'h00000003, 5'd8, 0, 0, 1, 1, 5'd8, 32'h00000003, 1, "alu");
        apply(0, 0, 0, 1, 1, 1, 2'd0, 0, 2'd0, c_RD, 32'h0, 5'd9,  0, 0, 1, 1, 5'd9,  32'hFFFFFF80, 1, "lb_ofs0");
        apply(0, 0, 0, 1, 1, 1, 2'd0, 1, 2'd3, c_RD, 32'h0, 5'd9,  0, 0, 1, 1, 5'd9,  32'h00000001, 1, "lbu_ofs3");
        apply(0, 0, 0, 1, 1, 1, 2'd0, 0, 2'd1, c_RD, 32'h0, 5'd9,  0, 0, 1, 1, 5'd9,  32'hFFFFFFF1, 1, "lb_ofs1");
        apply(0, 0, 0, 1, 1, 1, 2'd0, 0, 2'd2, c_RD, 32'h0, 5'd9,  0, 0, 1, 1, 5'd9,  32'h0000007F, 1, "lb_ofs2");
        apply(0, 0, 0, 1, 1, 1, 2'd1, 0, 2'd3, c_RD, 32'h0, 5'd11, 0, 0, 1, 1, 5'd11, 32'h00007F01, 1, "lh_ofs3");
        apply(0, 0, 0, 1, 1, 1, 2'd1, 1, 2'd0, c_RD, 32'h0, 5'd11, 0, 0, 1, 1, 5'd11, 32'h000080F1, 1, "lhu_ofs0");
        apply(0, 0, 0, 1, 1, 1, 2'd1, 0, 2'd1, c_RD, 32'h0, 5'd11, 0, 0, 1, 1, 5'd11, 32'hFFFF80F1, 1, "lh_ofs1");
        apply(0, 0, 0, 1, 1, 1, 2'd2, 0, 2'd2, c_RD, 32'h0, 5'd12, 0, 0, 1, 1, 5'd12, 32'h80F17F01, 1, "lw_ofs2");
        apply(0, 0, 0, 1, 1, 1, 2'd3, 1, 2'd3, c_RD, 32'h0, 5'd12, 0, 0, 1, 1, 5'd12, 32'h80F17F01, 1, "lfull");
        apply(0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd3, c_RD, 32'hDEADBEEF, 5'd13, 0, 0, 1, 1, 5'd13, 32'hDEADBEEF, 1, "alu_ignsize");
        apply(0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'h00000055, 5'd0, 0, 0, 1, 0, 5'd0, 32'h00000055, 1, "zero_reg");
        apply(0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'h00000077, 5'd5, 0, 0, 0, 0, 5'd0, 32'h0, 0, "bubble");
        apply(0, 0, 0, 1, 0, 0, 2'd0, 0, 2'd0, c_RD, 32'h00000099, 5'd6, 0, 0, 1, 0, 5'd6, 32'h00000099, 1, "no_regwrite");
        // Capture A, then stall while inputs change
        apply(0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'h12345678, 5'd10, 0, 0, 1, 1, 5'd10, 32'h12345678, 1, "capture_A");
        apply(0, 1, 0, 1, 1, 1, 2'd0, 0, 2'd0, c_RD, 32'hAAAAAAAA, 5'd20, 0, 0, 1, 1, 5'd10, 32'h12345678, 1, "stall1");
        apply(0, 1, 0, 0, 0, 0, 2'd1, 1, 2'd1, 32'h0, 32'hBBBBBBBB, 5'd21, 0, 0, 1, 1, 5'd10, 32'h12345678, 1, "stall2");
        apply(0, 1, 0, 1, 1, 0, 2'd2, 0, 2'd2, c_RD, 32'hCCCCCCCC, 5'd0,  0, 0, 1, 1, 5'd10, 32'h12345678, 1, "stall3");
        apply(0, 1, 1, 1, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'hDDDDDDDD, 5'd22, 0, 0, 0, 0, 5'd0, 32'h0, 0, "flush_stall");
        apply(0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'h0BADF00D, 5'd14, 0, 0, 1, 1, 5'd14, 32'h0BADF00D, 1, "capture_B");
        apply(1, 1, 1, 1, 1, 0, 2'd0, 0, 2'd0, c_RD, 32'hEEEEEEEE, 5'd15, 0, 0, 0, 0, 5'd0, 32'h0, 1, "rst_in_stall");
`ifdef WB_LINK_EN
        apply(0, 0, 0, 1, 1, 1, 2'd0, 0, 2'd0, c_RD, 32'h11111111, 5'd31, 1, 32'h00400010,
              1, 1, 5'd31, 32'h00400010, 1, "link");
`endif
        apply(0, 0, 0, 1, 1, 1, 2'd0, 1, 2'd1, c_RD, 32'h0, 5'd16, 0, 0, 1, 1, 5'd16, 32'h000000F1, 1, "lbu_ofs1");
        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
